// File: rtl/z80_bus_arbiter_pkg.sv
// Shared definitions for the A-Z80 external bus arbiter and its helpers.
//   arb_state_t : arbiter FSM states
//   MAX_REQ     : architectural maximum number of external requesters
//   rrIndex     : wrap-around index used by round-robin scans
package z80_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3,
        GAP     = 3'd4
    } arb_state_t;

    localparam int MAX_REQ = 8;

    // Position 'offset' steps above 'base', wrapped into 0..n-1.
    function automatic int rrIndex(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/z80_bus_arbiter_if.sv
// Bus-arbitration signal bundle between the arbiter, the CPU pins and the
// external masters.
//   req         : per-master level-held bus request
//   nBUSACK     : CPU bus acknowledge, active low
//   nBUSRQ      : CPU bus request, active low
//   grant       : one-hot grant to the owning master
//   bus_own     : an external master owns the bus
//   preempt     : one-cycle pulse when the holder is forced off
//   ack_timeout : one-cycle pulse when a request is abandoned
// modport master is the arbiter side, modport slave the CPU/master side.
interface z80_bus_arbiter_if #(
    parameter int NUM_REQ = 2
) ();

    logic [NUM_REQ-1:0] req;
    logic               nBUSACK;
    logic               nBUSRQ;
    logic [NUM_REQ-1:0] grant;
    logic               bus_own;
    logic               preempt;
    logic               ack_timeout;

    modport master (
        input  req, nBUSACK,
        output nBUSRQ, grant, bus_own, preempt, ack_timeout
    );

    modport slave (
        output req, nBUSACK,
        input  nBUSRQ, grant, bus_own, preempt, ack_timeout
    );

endinterface

// File: rtl/z80_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   req    : request vector
//   rrPtr  : index with highest priority this round
//   valid  : at least one request is set
//   winner : first set request scanning upward from rrPtr, wrapping
module z80_rr_pick
    import z80_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rrPtr,
    output logic               valid,
    output logic [PTR_W-1:0]   winner
);

    // Scan from rrPtr upward; the first set request found wins.
    always_comb begin : pickScan
        int   idx;
        logic hit;
        idx    = 0;
        hit    = 1'b0;
        valid  = 1'b0;
        winner = {PTR_W{1'b0}};
        for (int i = 0; i < MAX_REQ; i++) begin
            idx    = rrIndex(int'(rrPtr), i, NUM_REQ);
            hit    = (i < NUM_REQ) && !valid && req[idx];
            winner = hit ? PTR_W'(idx) : winner;
            valid  = valid | hit;
        end
    end

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares the A-Z80 external bus between the CPU and NUM_REQ external masters.
// Runs the nBUSRQ/nBUSACK handshake, picks requesters round-robin and gates
// the masters' drivers through a registered one-hot grant.
//   CLK, reset : system clock, synchronous active-high reset
//   bus        : arbitration bundle (master modport)
// Parameters: ACK_TIMEOUT (0 = wait forever), MAX_HOLD (0 = unlimited hold),
// CPU_GAP (minimum CPU-owned cycles between grants, 0 = none).
module z80_bus_arbiter
    import z80_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_HOLD    = 0,
    parameter int CPU_GAP     = 4
) (
    input logic               CLK,
    input logic               reset,
    z80_bus_arbiter_if.master bus
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WAIT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam int GAP_W  = $clog2(CPU_GAP) + 1;

    // Counter values on the last cycle of each timed phase.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((CPU_GAP > 0) ? CPU_GAP - 1 : 0);

    arb_state_t         state_r, stateNext_s;
    logic [PTR_W-1:0]   winner_r, winnerNext_s;
    logic [PTR_W-1:0]   rrPtr_r, rrPtrNext_s;
    logic [WAIT_W-1:0]  waitCnt_r, waitCntNext_s;
    logic [HOLD_W-1:0]  holdCnt_r, holdCntNext_s;
    logic [GAP_W-1:0]   gapCnt_r, gapCntNext_s;
    logic               nBusrq_r, nBusrqNext_s;
    logic [NUM_REQ-1:0] grant_r, grantNext_s;
    logic               busOwn_r, busOwnNext_s;
    logic               preempt_r, preemptNext_s;
    logic               ackTimeout_r, ackTimeoutNext_s;

    logic               pickValid_s;
    logic [PTR_W-1:0]   pickWinner_s;
    logic [NUM_REQ-1:0] winnerMask_s;
    logic               winnerReq_s;
    logic               othersReq_s;
    logic               holdSat_s;
    logic               holdDone_s;
    logic [PTR_W-1:0]   ptrAfter_s;

    z80_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req     (bus.req),
        .rrPtr   (rrPtr_r),
        .valid   (pickValid_s),
        .winner  (pickWinner_s)
    );

    assign winnerMask_s = NUM_REQ'(1'b1) << winner_r;
    assign winnerReq_s  = |(bus.req & winnerMask_s);
    assign othersReq_s  = |(bus.req & ~winnerMask_s);
    // The hold counter parks at its last value so a late competitor preempts at once.
    assign holdSat_s    = (holdCnt_r == HOLD_LAST);
    assign holdDone_s   = (MAX_HOLD != 0) && holdSat_s;
    assign ptrAfter_s   = (int'(winner_r) == NUM_REQ - 1) ? {PTR_W{1'b0}} : winner_r + PTR_W'(1'b1);

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        stateNext_s      = state_r;
        winnerNext_s     = winner_r;
        rrPtrNext_s      = rrPtr_r;
        waitCntNext_s    = waitCnt_r;
        holdCntNext_s    = holdCnt_r;
        gapCntNext_s     = gapCnt_r;
        nBusrqNext_s     = nBusrq_r;
        grantNext_s      = grant_r;
        busOwnNext_s     = busOwn_r;
        preemptNext_s    = 1'b0;
        ackTimeoutNext_s = 1'b0;
        case (state_r)
            IDLE: begin
                nBusrqNext_s = 1'b1;
                grantNext_s  = {NUM_REQ{1'b0}};
                busOwnNext_s = 1'b0;
                if (pickValid_s) begin
                    winnerNext_s  = pickWinner_s;
                    waitCntNext_s = {WAIT_W{1'b0}};
                    nBusrqNext_s  = 1'b0;
                    stateNext_s   = REQ;
                end else begin
                    stateNext_s   = IDLE;
                end
            end
            REQ: begin
                // An acknowledge on the timeout cycle still wins.
                if (!bus.nBUSACK) begin
                    if (winnerReq_s) begin
                        grantNext_s   = winnerMask_s;
                        busOwnNext_s  = 1'b1;
                        holdCntNext_s = {HOLD_W{1'b0}};
                        stateNext_s   = GRANT;
                    end else begin
                        nBusrqNext_s  = 1'b1;
                        stateNext_s   = RELEASE;
                    end
                end else if ((ACK_TIMEOUT != 0) && (waitCnt_r == WAIT_LAST)) begin
                    ackTimeoutNext_s = 1'b1;
                    nBusrqNext_s     = 1'b1;
                    stateNext_s      = RELEASE;
                end else begin
                    waitCntNext_s    = waitCnt_r + WAIT_W'(1'b1);
                end
            end
            GRANT: begin
                if (!winnerReq_s || (holdDone_s && othersReq_s)) begin
                    // A voluntary drop takes precedence over a preemption.
                    preemptNext_s = winnerReq_s;
                    grantNext_s   = {NUM_REQ{1'b0}};
                    busOwnNext_s  = 1'b0;
                    nBusrqNext_s  = 1'b1;
                    rrPtrNext_s   = ptrAfter_s;
                    stateNext_s   = RELEASE;
                end else begin
                    holdCntNext_s = holdSat_s ? holdCnt_r : holdCnt_r + HOLD_W'(1'b1);
                end
            end
            RELEASE: begin
                nBusrqNext_s = 1'b1;
                grantNext_s  = {NUM_REQ{1'b0}};
                busOwnNext_s = 1'b0;
                if (bus.nBUSACK) begin
                    gapCntNext_s = {GAP_W{1'b0}};
                    stateNext_s  = (CPU_GAP == 0) ? IDLE : GAP;
                end else begin
                    stateNext_s  = RELEASE;
                end
            end
            GAP: begin
                if (gapCnt_r == GAP_LAST) begin
                    stateNext_s  = IDLE;
                end else begin
                    gapCntNext_s = gapCnt_r + GAP_W'(1'b1);
                end
            end
            default: begin
                stateNext_s  = IDLE;
                nBusrqNext_s = 1'b1;
                grantNext_s  = {NUM_REQ{1'b0}};
                busOwnNext_s = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r      <= IDLE;
            winner_r     <= {PTR_W{1'b0}};
            rrPtr_r      <= {PTR_W{1'b0}};
            waitCnt_r    <= {WAIT_W{1'b0}};
            holdCnt_r    <= {HOLD_W{1'b0}};
            gapCnt_r     <= {GAP_W{1'b0}};
            nBusrq_r     <= 1'b1;
            grant_r      <= {NUM_REQ{1'b0}};
            busOwn_r     <= 1'b0;
            preempt_r    <= 1'b0;
            ackTimeout_r <= 1'b0;
        end else begin
            state_r      <= stateNext_s;
            winner_r     <= winnerNext_s;
            rrPtr_r      <= rrPtrNext_s;
            waitCnt_r    <= waitCntNext_s;
            holdCnt_r    <= holdCntNext_s;
            gapCnt_r     <= gapCntNext_s;
            nBusrq_r     <= nBusrqNext_s;
            grant_r      <= grantNext_s;
            busOwn_r     <= busOwnNext_s;
            preempt_r    <= preemptNext_s;
            ackTimeout_r <= ackTimeoutNext_s;
        end
    end

    assign bus.nBUSRQ      = nBusrq_r;
    assign bus.grant       = grant_r;
    assign bus.bus_own     = busOwn_r;
    assign bus.preempt     = preempt_r;
    assign bus.ack_timeout = ackTimeout_r;

endmodule
